hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter MULDIV_CYCLES, default 8, SHALL set the fixed execute latency of a multiply/divide in cycles, legal range 2..32.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 IDRs  input  5  SHALL carry the rs field of the instruction in ID.
REQ-005 IDRt  input  5  SHALL carry the rt field of the instruction in ID.
REQ-006 IDUsesRt  input  1  SHALL indicate that the ID instruction reads rt as a source.
REQ-007 IDEXMemRead  input  1  SHALL indicate that the instruction in EX is a load.
REQ-008 IDEXRt  input  5  SHALL carry the destination register of the instruction in EX.
REQ-009 BranchTaken  input  1  SHALL indicate a taken branch or jump resolved in ID this cycle.
REQ-010 IDIsMulDiv  input  1  SHALL indicate that the ID instruction is mult/multu/div/divu.
REQ-011 IDReadsHiLo  input  1  SHALL indicate that the ID instruction is mfhi/mflo.
REQ-012 PCWrite  output  1  SHALL be 1 when the PC may advance.
REQ-013 IFIDControl  output  1  SHALL be 1 to hold the IF/ID register; it drives that register's control input directly.
REQ-014 IFIDFlush  output  1  SHALL be 1 to zero the IF/ID register at the next edge.
REQ-015 IDEXBubble  output  1  SHALL be 1 to load a NOP into ID/EX at the next edge.
REQ-016 MulDivBusy  output  1  SHALL be 1 while a multiply/divide is in flight.
REQ-017 StallCycles  output  16  SHALL count cycles in which PCWrite was 0 outside reset.

Function
REQ-018 The FSM SHALL have two states, RUN and MD_BUSY, plus a 5-bit down-counter MdCnt.
REQ-019 Outputs SHALL be combinational from the current state and inputs, so a stall takes effect in the same cycle the hazard is presented.
REQ-020 LoadUse SHALL be true when IDEXMemRead=1, IDEXRt!=0, and either IDEXRt==IDRs or (IDUsesRt=1 and IDEXRt==IDRt).
REQ-021 MdHaz SHALL be true in MD_BUSY when IDReadsHiLo=1 or IDIsMulDiv=1.
REQ-022 Stall = LoadUse OR MdHaz; when Stall is true: PCWrite=0, IFIDControl=1, IDEXBubble=1, IFIDFlush=0.
REQ-023 When Stall is false: PCWrite=1 and IFIDControl=0; IFIDFlush SHALL equal BranchTaken; IDEXBubble SHALL be 0.
REQ-024 BranchTaken during a stall SHALL be ignored; the branch is re-evaluated when the stall clears.
REQ-025 In RUN, IDIsMulDiv=1 with Stall false SHALL set MdCnt to MULDIV_CYCLES-1 and move the FSM to MD_BUSY at the next edge.
REQ-026 In MD_BUSY, MdCnt SHALL decrement every cycle; when MdCnt==0 the FSM SHALL return to RUN at that edge.
REQ-027 A mul/div in ID at the MD_BUSY exit cycle SHALL still stall; it is issued the following cycle from RUN.
REQ-028 MulDivBusy SHALL be 1 exactly when the state is MD_BUSY.
REQ-029 StallCycles SHALL increment when PCWrite=0 and Reset=0, and SHALL wrap from 0xFFFF to 0.

Reset
REQ-030 While Reset=1: state=RUN, MdCnt=0, StallCycles=0 at the edge; outputs PCWrite=0, IFIDControl=0, IFIDFlush=1, IDEXBubble=1, MulDivBusy=0.
REQ-031 Reset asserted in MD_BUSY SHALL abandon the operation and leave the FSM in RUN with no residual stall on the first cycle after release.

Structure
REQ-032 A shared package SHALL hold the state encoding (RUN=0, MD_BUSY=1) and the MULDIV_CYCLES default.
REQ-033 The hazard compare of REQ-020 SHALL be one sub-module, load_use_detect; the rest stays in the top level.

Verification
REQ-034 Case 1: IDEXMemRead=1, IDEXRt=5, IDRs=5 -> one cycle with PCWrite=0, IFIDControl=1, IDEXBubble=1; next cycle with IDEXMemRead=0 -> PCWrite=1; StallCycles=1.
REQ-035 Case 2: IDEXRt=0 with IDEXMemRead=1 and IDRs=0 -> no stall; also IDRt matches but IDUsesRt=0 -> no stall.
REQ-036 Case 3: BranchTaken=1 with no hazard -> IFIDFlush=1, PCWrite=1; BranchTaken=1 together with LoadUse -> IFIDFlush=0 and stall.
REQ-037 Case 4: IDIsMulDiv for 1 cycle, then IDReadsHiLo held -> MulDivBusy=1 for 8 cycles, stall for 8 cycles, PCWrite=1 on cycle 9.
REQ-038 Case 5: Reset pulsed on cycle 3 of MD_BUSY -> MulDivBusy=0 and state RUN after release; StallCycles=0.
REQ-039 Case 6: force 65536 stall cycles -> StallCycles wraps to 0.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings and defaults for the hazard/stall controller.
// Imported by the top level and the load-use comparator.
package hazard_stall_controller_pkg;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    localparam int MULDIV_CYCLES_DEF = 8;
    localparam int MD_CNT_W          = 5;

    // Reload value for the mul/div down-counter; the counter runs N-1 .. 0.
    function automatic logic [MD_CNT_W-1:0] md_reload(input int cycles);
        return MD_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Load-use comparator: flags an ID source that matches the destination of a
// load currently in EX. Register 0 never creates a hazard.
module load_use_detect
    import hazard_stall_controller_pkg::*;
(
    input  logic       IDEXMemRead_i,
    input  logic [4:0] IDEXRt_i,
    input  logic [4:0] IDRs_i,
    input  logic [4:0] IDRt_i,
    input  logic       IDUsesRt_i,
    output logic       LoadUse_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match  = (IDEXRt_i == IDRs_i);
    assign rt_match  = IDUsesRt_i && (IDEXRt_i == IDRt_i);
    assign LoadUse_o = IDEXMemRead_i && (IDEXRt_i != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes and a
// fixed-latency mul/div interlock, plus a free-running stall-cycle counter.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic [4:0]  IDRs_i,
    input  logic [4:0]  IDRt_i,
    input  logic        IDUsesRt_i,
    input  logic        IDEXMemRead_i,
    input  logic [4:0]  IDEXRt_i,
    input  logic        BranchTaken_i,
    input  logic        IDIsMulDiv_i,
    input  logic        IDReadsHiLo_i,
    output logic        PCWrite_o,
    output logic        IFIDControl_o,
    output logic        IFIDFlush_o,
    output logic        IDEXBubble_o,
    output logic        MulDivBusy_o,
    output logic [15:0] StallCycles_o
);

    logic [0:0]          state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic md_haz;
    logic stall;

    load_use_detect u_load_use_detect (
        .IDEXMemRead_i (IDEXMemRead_i),
        .IDEXRt_i      (IDEXRt_i),
        .IDRs_i        (IDRs_i),
        .IDRt_i        (IDRt_i),
        .IDUsesRt_i    (IDUsesRt_i),
        .LoadUse_o     (load_use)
    );

    // Any mul/div or HI/LO reader waits out the whole busy window, including the exit cycle.
    assign md_haz = (state_q == ST_MD_BUSY) && (IDReadsHiLo_i || IDIsMulDiv_i);
    assign stall  = load_use || md_haz;

    always_comb begin
        PCWrite_o     = 1'b1;
        IFIDControl_o = 1'b0;
        IFIDFlush_o   = BranchTaken_i;
        IDEXBubble_o  = 1'b0;
        MulDivBusy_o  = (state_q == ST_MD_BUSY);
        if (Reset_i) begin
            PCWrite_o     = 1'b0;
            IFIDControl_o = 1'b0;
            IFIDFlush_o   = 1'b1;
            IDEXBubble_o  = 1'b1;
            MulDivBusy_o  = 1'b0;
        end else if (stall) begin
            // The branch outcome is dropped; ID re-resolves it once the stall clears.
            PCWrite_o     = 1'b0;
            IFIDControl_o = 1'b1;
            IFIDFlush_o   = 1'b0;
            IDEXBubble_o  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite_o) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        case (state_q)
            ST_RUN: begin
                if (IDIsMulDiv_i && !stall) begin
                    state_d  = ST_MD_BUSY;
                    md_cnt_d = md_reload(MULDIV_CYCLES);
                end
            end
            default: begin
                if (md_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: load-use, branch flush,
// mul/div interlock, reset abandon and stall-counter wrap.
module tb_hazard_stall_controller;

    logic        Clk_i = 1'b0;
    logic        Reset_i;
    logic [4:0]  IDRs_i, IDRt_i, IDEXRt_i;
    logic        IDUsesRt_i, IDEXMemRead_i, BranchTaken_i, IDIsMulDiv_i, IDReadsHiLo_i;
    logic        PCWrite_o, IFIDControl_o, IFIDFlush_o, IDEXBubble_o, MulDivBusy_o;
    logic [15:0] StallCycles_o;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_stall_controller #(.MULDIV_CYCLES(8)) dut (
        .Clk_i         (Clk_i),
        .Reset_i       (Reset_i),
        .IDRs_i        (IDRs_i),
        .IDRt_i        (IDRt_i),
        .IDUsesRt_i    (IDUsesRt_i),
        .IDEXMemRead_i (IDEXMemRead_i),
        .IDEXRt_i      (IDEXRt_i),
        .BranchTaken_i (BranchTaken_i),
        .IDIsMulDiv_i  (IDIsMulDiv_i),
        .IDReadsHiLo_i (IDReadsHiLo_i),
        .PCWrite_o     (PCWrite_o),
        .IFIDControl_o (IFIDControl_o),
        .IFIDFlush_o   (IFIDFlush_o),
        .IDEXBubble_o  (IDEXBubble_o),
        .MulDivBusy_o  (MulDivBusy_o),
        .StallCycles_o (StallCycles_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are combinational; inputs change #1 after the edge, checks happen #2 later.
    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        IDRs_i = 5'd0; IDRt_i = 5'd0; IDEXRt_i = 5'd0;
        IDUsesRt_i = 1'b0; IDEXMemRead_i = 1'b0; BranchTaken_i = 1'b0;
        IDIsMulDiv_i = 1'b0; IDReadsHiLo_i = 1'b0;
    endtask

    initial begin
        idle();
        Reset_i = 1'b1;
        // Reset outputs
        settle();
        chk("rst_pcwrite", PCWrite_o, 0);
        chk("rst_ifidctl", IFIDControl_o, 0);
        chk("rst_flush", IFIDFlush_o, 1);
        chk("rst_bubble", IDEXBubble_o, 1);
        chk("rst_busy", MulDivBusy_o, 0);
        tick();
        chk("rst_stallcnt", StallCycles_o, 0);
        Reset_i = 1'b0;
        settle();
        chk("idle_pcwrite", PCWrite_o, 1);
        chk("idle_flush", IFIDFlush_o, 0);
        chk("idle_bubble", IDEXBubble_o, 0);

        // Case 1: load-use on rs
        IDEXMemRead_i = 1'b1; IDEXRt_i = 5'd5; IDRs_i = 5'd5;
        settle();
        chk("c1_pcwrite", PCWrite_o, 0);
        chk("c1_ifidctl", IFIDControl_o, 1);
        chk("c1_bubble", IDEXBubble_o, 1);
        chk("c1_flush", IFIDFlush_o, 0);
        tick();
        IDEXMemRead_i = 1'b0;
        settle();
        chk("c1_release", PCWrite_o, 1);
        chk("c1_stallcnt", StallCycles_o, 1);

        // Case 2: r0 never hazards; rt only when used
        IDEXMemRead_i = 1'b1; IDEXRt_i = 5'd0; IDRs_i = 5'd0;
        settle();
        chk("c2_r0", PCWrite_o, 1);
        IDEXRt_i = 5'd7; IDRt_i = 5'd7; IDRs_i = 5'd3; IDUsesRt_i = 1'b0;
        settle();
        chk("c2_rt_unused", PCWrite_o, 1);
        IDUsesRt_i = 1'b1;
        settle();
        chk("c2_rt_used", PCWrite_o, 0);
        tick();
        idle();
        settle();
        chk("c2_stallcnt", StallCycles_o, 2);

        // Case 3: branch flush, suppressed during a stall
        BranchTaken_i = 1'b1;
        settle();
        chk("c3_flush", IFIDFlush_o, 1);
        chk("c3_pcwrite", PCWrite_o, 1);
        IDEXMemRead_i = 1'b1; IDEXRt_i = 5'd9; IDRt_i = 5'd9; IDUsesRt_i = 1'b1;
        settle();
        chk("c3_stall_flush", IFIDFlush_o, 0);
        chk("c3_stall_pcwrite", PCWrite_o, 0);
        tick();
        idle();
        settle();
        chk("c3_stallcnt", StallCycles_o, 3);

        // Case 4: mul/div issue, then HI/LO reader waits 8 cycles
        IDIsMulDiv_i = 1'b1;
        settle();
        chk("c4_issue_pcwrite", PCWrite_o, 1);
        chk("c4_issue_busy", MulDivBusy_o, 0);
        tick();
        IDIsMulDiv_i = 1'b0; IDReadsHiLo_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("c4_busy%0d", i), MulDivBusy_o, 1);
            chk($sformatf("c4_stall%0d", i), PCWrite_o, 0);
            tick();
        end
        settle();
        chk("c4_done_busy", MulDivBusy_o, 0);
        chk("c4_done_pcwrite", PCWrite_o, 1);
        chk("c4_stallcnt", StallCycles_o, 11);

        // Back-to-back mul/div: the second waits, including the exit cycle
        IDReadsHiLo_i = 1'b0; IDIsMulDiv_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("c4b_stall%0d", i), PCWrite_o, 0);
            tick();
        end
        settle();
        chk("c4b_reissue_pcwrite", PCWrite_o, 1);
        chk("c4b_stallcnt", StallCycles_o, 19);
        tick();
        settle();
        chk("c4b_reissue_busy", MulDivBusy_o, 1);

        // Case 5: reset in the 3rd MD_BUSY cycle abandons the operation
        IDIsMulDiv_i = 1'b0;
        tick();
        tick();
        Reset_i = 1'b1;
        settle();
        chk("c5_rst_busy", MulDivBusy_o, 0);
        chk("c5_rst_pcwrite", PCWrite_o, 0);
        tick();
        Reset_i = 1'b0;
        IDReadsHiLo_i = 1'b1;
        settle();
        chk("c5_post_busy", MulDivBusy_o, 0);
        chk("c5_post_pcwrite", PCWrite_o, 1);
        chk("c5_post_stallcnt", StallCycles_o, 0);
        tick();
        idle();
        settle();
        chk("c5_post2_stallcnt", StallCycles_o, 0);

        // Case 6: stall counter wraps
        IDEXMemRead_i = 1'b1; IDEXRt_i = 5'd5; IDRs_i = 5'd5;
        repeat (65535) tick();
        settle();
        chk("c6_max", StallCycles_o, 16'hFFFF);
        tick();
        settle();
        chk("c6_wrap", StallCycles_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
